// File: rtl/bp_mem_resp_delay_if.sv
`default_nettype none
// ============================================================================
// Module   : bp_mem_resp_delay_if
// Brief    : Ready/valid beat channel used on both sides of the delay buffer.
// Revision : 1.0
// ============================================================================
interface bp_mem_resp_delay_if #(
  parameter int width_p = 64
) ();
  logic [width_p-1:0] data;
  logic               v;
  logic               ready;

  modport master (output data, output v, input ready);
  modport slave  (input data, input v, output ready);
endinterface
`default_nettype wire

// File: rtl/bp_mem_resp_delay.sv
`default_nettype none
// ============================================================================
// Module   : bp_mem_resp_delay
// Brief    : In-order buffer holding each beat at least latency_p cycles.
// Revision : 1.0
// ============================================================================
module bp_mem_resp_delay #(
  parameter int  width_p      = 64,
  parameter int  els_p        = 4,
  parameter int  latency_p    = 8,
  localparam int lg_els_lp    = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int cnt_width_lp = ((latency_p + 1) > 1) ? $clog2(latency_p + 1) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  bp_mem_resp_delay_if.slave   up_if,
  bp_mem_resp_delay_if.master  dn_if,
  output logic [lg_els_lp:0]   count_o
);

  localparam logic [lg_els_lp:0]      c_els      = (lg_els_lp + 1)'(els_p);
  localparam logic [lg_els_lp-1:0]    c_last_ptr = lg_els_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] c_load     = cnt_width_lp'(latency_p - 1);
  localparam logic [cnt_width_lp-1:0] c_one      = cnt_width_lp'(1);

  logic [width_p-1:0]      data_q [els_p];
  logic [cnt_width_lp-1:0] cnt_q  [els_p];

  logic [lg_els_lp-1:0] wptr_q, wptr_d;
  logic [lg_els_lp-1:0] rptr_q, rptr_d;
  logic [lg_els_lp:0]   occ_q,  occ_d;

  logic w_full;
  logic w_empty;
  logic w_head_ripe;
  logic w_enq;
  logic w_deq;

  assign w_full      = (occ_q == c_els);
  assign w_empty     = (occ_q == '0);
  assign w_head_ripe = (cnt_q[rptr_q] == '0);

  // Outputs are forced idle for the whole reset cycle, not just after the edge.
  assign up_if.ready = ~w_full & ~reset_i;
  assign dn_if.v     = ~w_empty & w_head_ripe & ~reset_i;
  assign dn_if.data  = data_q[rptr_q];
  assign count_o     = reset_i ? '0 : occ_q;

  assign w_enq = up_if.v & up_if.ready;
  assign w_deq = dn_if.v & dn_if.ready;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (w_enq) begin
      wptr_d = (wptr_q == c_last_ptr) ? '0 : wptr_q + lg_els_lp'(1);
    end
    if (w_deq) begin
      rptr_d = (rptr_q == c_last_ptr) ? '0 : rptr_q + lg_els_lp'(1);
    end
    case ({w_enq, w_deq})
      2'b10:   occ_d = occ_q + (lg_els_lp + 1)'(1);
      2'b01:   occ_d = occ_q - (lg_els_lp + 1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  // Every slot ages on its own so a stalled head never holds back later beats.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < els_p; i++) begin
      if (reset_i) begin
        cnt_q[i] <= '0;
      end else if (w_enq && (wptr_q == lg_els_lp'(i))) begin
        cnt_q[i] <= c_load;
      end else if (cnt_q[i] != '0) begin
        cnt_q[i] <= cnt_q[i] - c_one;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      data_q[wptr_q] <= up_if.data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (els_p >= 2 && latency_p >= 1)
        else $error("bp_mem_resp_delay: illegal parameters els_p=%0d latency_p=%0d", els_p, latency_p);
      assert (occ_q <= c_els)
        else $error("bp_mem_resp_delay: occupancy %0d exceeds depth %0d", occ_q, els_p);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_mem_resp_delay.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_mem_resp_delay
// Brief    : Directed/random bench with a timestamp-queue reference model.
// Revision : 1.0
// ============================================================================
module tb_bp_mem_resp_delay;

  localparam int c_w     = 64;
  localparam int c_els   = 4;
  localparam int c_lat_a = 8;
  localparam int c_lat_b = 1;

  typedef struct {
    logic [63:0] d;
    int          t;
  } ent_t;

  logic clk;
  logic rst;
  logic [2:0] cnt_a;
  logic [2:0] cnt_b;

  bp_mem_resp_delay_if #(.width_p(c_w)) a_up ();
  bp_mem_resp_delay_if #(.width_p(c_w)) a_dn ();
  bp_mem_resp_delay_if #(.width_p(c_w)) b_up ();
  bp_mem_resp_delay_if #(.width_p(c_w)) b_dn ();

  bp_mem_resp_delay #(.width_p(c_w), .els_p(c_els), .latency_p(c_lat_a)) u_dut_a (
    .clk_i   (clk),
    .reset_i (rst),
    .up_if   (a_up),
    .dn_if   (a_dn),
    .count_o (cnt_a)
  );

  bp_mem_resp_delay #(.width_p(c_w), .els_p(c_els), .latency_p(c_lat_b)) u_dut_b (
    .clk_i   (clk),
    .reset_i (rst),
    .up_if   (b_up),
    .dn_if   (b_dn),
    .count_o (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  ent_t        qa[$];
  ent_t        qb[$];
  logic [63:0] got_a[$];
  logic [63:0] got_b[$];
  logic [63:0] exp_l[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare both DUTs to the model, then advance across the edge.
  task automatic step();
    logic m_rdy_a, m_v_a, m_rdy_b, m_v_b;
    #1;
    m_rdy_a = !rst && (qa.size() < c_els);
    m_v_a   = !rst && (qa.size() > 0) && (edge_n + 1 >= qa[0].t + c_lat_a);
    m_rdy_b = !rst && (qb.size() < c_els);
    m_v_b   = !rst && (qb.size() > 0) && (edge_n + 1 >= qb[0].t + c_lat_b);
    chk("a_ready", 64'(a_up.ready), 64'(m_rdy_a));
    chk("a_v",     64'(a_dn.v),     64'(m_v_a));
    chk("a_count", 64'(cnt_a),      rst ? 64'd0 : 64'(qa.size()));
    if (m_v_a) chk("a_data", a_dn.data, qa[0].d);
    chk("b_ready", 64'(b_up.ready), 64'(m_rdy_b));
    chk("b_v",     64'(b_dn.v),     64'(m_v_b));
    chk("b_count", 64'(cnt_b),      rst ? 64'd0 : 64'(qb.size()));
    if (m_v_b) chk("b_data", b_dn.data, qb[0].d);
    if (a_dn.v && a_dn.ready) got_a.push_back(a_dn.data);
    if (b_dn.v && b_dn.ready) got_b.push_back(b_dn.data);
    @(posedge clk);
    edge_n++;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (m_v_a && a_dn.ready) void'(qa.pop_front());
      if (m_rdy_a && a_up.v) qa.push_back('{d: a_up.data, t: edge_n});
      if (m_v_b && b_dn.ready) void'(qb.pop_front());
      if (m_rdy_b && b_up.v) qb.push_back('{d: b_up.data, t: edge_n});
    end
    #1;
  endtask

  initial begin
    int sent_n;
    rst        = 1'b1;
    a_up.v     = 1'b0;
    a_up.data  = '0;
    a_dn.ready = 1'b0;
    b_up.v     = 1'b0;
    b_up.data  = '0;
    b_dn.ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) step();
    rst = 1'b0;

    // Single beat through the 8-cycle buffer.
    a_up.v = 1'b1; a_up.data = 64'hA5; a_dn.ready = 1'b1;
    step();
    a_up.v = 1'b0;
    repeat (12) step();
    chk("single_n", 64'(got_a.size()), 64'd1);
    chk("single_d", got_a[0], 64'hA5);

    // Burst fill with downstream stalled, then drain.
    got_a.delete();
    a_dn.ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      a_up.v = 1'b1; a_up.data = 64'(k);
      step();
    end
    a_up.v = 1'b0;
    chk("burst_full_ready", 64'(a_up.ready), 64'd0);
    chk("burst_full_count", 64'(cnt_a), 64'd4);
    repeat (20) step();
    a_dn.ready = 1'b1;
    repeat (6) step();
    chk("burst_n", 64'(got_a.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk("burst_d", got_a[k], 64'(k + 1));

    // Matured head held under backpressure.
    got_a.delete();
    a_dn.ready = 1'b0;
    a_up.v = 1'b1; a_up.data = 64'h3C; step();
    a_up.data = 64'h3D; step();
    a_up.v = 1'b0;
    repeat (10) step();
    repeat (5) begin
      chk("hold_v", 64'(a_dn.v), 64'd1);
      chk("hold_d", a_dn.data, 64'h3C);
      step();
    end
    a_dn.ready = 1'b1;
    repeat (3) step();
    chk("hold_n", 64'(got_a.size()), 64'd2);
    chk("hold_d0", got_a[0], 64'h3C);
    chk("hold_d1", got_a[1], 64'h3D);

    // Random wrap-around stream of 10 beats.
    got_a.delete();
    exp_l.delete();
    sent_n = 0;
    for (int i = 0; i < 400 && got_a.size() < 10; i++) begin
      a_dn.ready = 1'($urandom_range(0, 1));
      if (sent_n < 10 && $urandom_range(0, 2) != 0) begin
        a_up.v = 1'b1;
        a_up.data = {$urandom, $urandom};
      end else begin
        a_up.v = 1'b0;
      end
      if (a_up.v && a_up.ready) begin
        exp_l.push_back(a_up.data);
        sent_n++;
      end
      step();
    end
    a_up.v = 1'b0;
    chk("wrap_n", 64'(got_a.size()), 64'd10);
    for (int k = 0; k < 10; k++) chk("wrap_d", got_a[k], exp_l[k]);

    // Streaming through the 1-cycle instance.
    got_b.delete();
    exp_l.delete();
    b_dn.ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      b_up.v = 1'b1; b_up.data = 64'(16'h100 + k);
      if (k > 0) begin
        chk("stream_v", 64'(b_dn.v), 64'd1);
        chk("stream_count", 64'(cnt_b), 64'd1);
      end
      step();
    end
    b_up.v = 1'b0;
    step();
    chk("stream_n", 64'(got_b.size()), 64'd20);
    for (int k = 0; k < 20; k++) chk("stream_d", got_b[k], 64'(16'h100 + k));

    // Reset with beats in flight; only the fresh beat may appear.
    got_a.delete();
    a_dn.ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_up.v = 1'b1; a_up.data = 64'(16'hE0 + k);
      step();
    end
    a_up.v = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_up.v = 1'b1; a_up.data = 64'h77;
    step();
    a_up.v = 1'b0;
    repeat (c_lat_a - 1) begin
      chk("rst_quiet_v", 64'(a_dn.v), 64'd0);
      step();
    end
    chk("rst_new_v", 64'(a_dn.v), 64'd1);
    chk("rst_new_d", a_dn.data, 64'h77);
    repeat (15) step();
    chk("rst_n", 64'(got_a.size()), 64'd1);
    chk("rst_d", got_a[0], 64'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
